// File: rtl/pkt_buffer_write_if.sv
// pkt_buffer_write_if: bufid supply, packet line input and packet RAM write/status bus
interface pkt_buffer_write_if;
  logic         i_pkt_bufid_wr;
  logic [8:0]   iv_pkt_bufid;
  logic         o_bufid_ready;
  logic         i_pkt_wr;
  logic [133:0] iv_pkt;
  logic         o_pkt_wr_en;
  logic [15:0]  ov_pkt_waddr;
  logic [133:0] ov_pkt_wdata;
  logic         o_pkt_done;
  logic [8:0]   ov_done_bufid;
  logic [7:0]   ov_done_len;
  logic         o_done_err;
  logic [15:0]  ov_pkt_cnt;
  logic [15:0]  ov_discard_cnt;
  logic [1:0]   pkt_buffer_write_state;
  modport master (
    output i_pkt_bufid_wr, iv_pkt_bufid, i_pkt_wr, iv_pkt,
    input  o_bufid_ready, o_pkt_wr_en, ov_pkt_waddr, ov_pkt_wdata, o_pkt_done,
           ov_done_bufid, ov_done_len, o_done_err, ov_pkt_cnt, ov_discard_cnt,
           pkt_buffer_write_state
  );
  modport slave (
    input  i_pkt_bufid_wr, iv_pkt_bufid, i_pkt_wr, iv_pkt,
    output o_bufid_ready, o_pkt_wr_en, ov_pkt_waddr, ov_pkt_wdata, o_pkt_done,
           ov_done_bufid, ov_done_len, o_done_err, ov_pkt_cnt, ov_discard_cnt,
           pkt_buffer_write_state
  );
endinterface

// File: rtl/pkt_buffer_write.sv
// pkt_buffer_write: writes packet lines into per-bufid RAM pages from a 2-entry bufid FIFO
// PKT_BUFFER_WRITE_OVERLEN_CHECK_EN: stop writing after 128 lines and flag the packet as truncated
module pkt_buffer_write (
  input logic i_clk,
  input logic i_rst,
  pkt_buffer_write_if.slave bus
);
`ifdef PKT_BUFFER_WRITE_OVERLEN_CHECK_EN
  localparam bit ovl_en = 1'b1;
`else
  localparam bit ovl_en = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DISCARD = 2'd2} state_t;
  state_t state, state_n;
  logic [8:0] fifo [2];
  logic rp, wp;
  logic [1:0] cnt;
  logic [8:0] bid, bid_n, start_bid, p_bid;
  logic [6:0] idx, idx_n, n;
  logic full, full_n;
  logic is_head, is_tail, avail, start, pop, push, wbody, we, term, disc_inc, err;
  logic [15:0] waddr;
  logic [7:0] len, p_len;
  logic p_done, p_err;
  always_comb begin
    is_head = bus.i_pkt_wr && bus.iv_pkt[133:132] == 2'b01;
    is_tail = bus.i_pkt_wr && bus.iv_pkt[133:132] == 2'b10;
    avail = cnt != 2'd0;
    start = is_head && (avail || bus.i_pkt_bufid_wr);
    pop = is_head && avail;
    // a head with an empty FIFO consumes the incoming bufid directly instead of queueing it
    push = bus.i_pkt_bufid_wr && !(is_head && !avail) && (cnt != 2'd2 || pop);
    start_bid = avail ? fifo[rp] : bus.iv_pkt_bufid;
    wbody = state == WRITE && bus.i_pkt_wr && !is_head;
    we = start || (wbody && !full);
    waddr = start ? {start_bid, 7'd0} : {bid, idx};
    term = state == WRITE && (is_tail || is_head);
    disc_inc = state == DISCARD && (is_tail || is_head);
    n = idx + {6'd0, is_tail};
    len = (full || n == 7'd0) ? 8'd128 : {1'b0, n};
    err = is_head || (ovl_en && full);
    state_n = is_head ? (start ? WRITE : DISCARD) : (is_tail && state != IDLE) ? IDLE : state;
    bid_n = start ? start_bid : bid;
    idx_n = start ? 7'd1 : (wbody && !full) ? idx + 7'd1 : idx;
    full_n = start ? 1'b0 : (ovl_en && wbody && idx == 7'd127) ? 1'b1 : full;
  end
  assign bus.o_bufid_ready = cnt != 2'd2;
  assign bus.pkt_buffer_write_state = state;
  always_ff @(posedge i_clk)
    if (push && !i_rst) fifo[wp] <= bus.iv_pkt_bufid;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rp <= 1'b0;
      wp <= 1'b0;
      cnt <= 2'd0;
      bid <= 9'd0;
      idx <= 7'd0;
      full <= 1'b0;
      p_done <= 1'b0;
      p_bid <= 9'd0;
      p_len <= 8'd0;
      p_err <= 1'b0;
      bus.o_pkt_wr_en <= 1'b0;
      bus.ov_pkt_waddr <= 16'd0;
      bus.ov_pkt_wdata <= 134'd0;
      bus.o_pkt_done <= 1'b0;
      bus.ov_done_bufid <= 9'd0;
      bus.ov_done_len <= 8'd0;
      bus.o_done_err <= 1'b0;
      bus.ov_pkt_cnt <= 16'd0;
      bus.ov_discard_cnt <= 16'd0;
    end else begin
      state <= state_n;
      rp <= rp ^ pop;
      wp <= wp ^ push;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      bid <= bid_n;
      idx <= idx_n;
      full <= full_n;
      p_done <= term;
      p_bid <= bid;
      p_len <= len;
      p_err <= err;
      bus.o_pkt_wr_en <= we;
      bus.ov_pkt_waddr <= waddr;
      bus.ov_pkt_wdata <= bus.iv_pkt;
      bus.o_pkt_done <= p_done;
      bus.ov_done_bufid <= p_bid;
      bus.ov_done_len <= p_len;
      bus.o_done_err <= p_err;
      bus.ov_pkt_cnt <= bus.ov_pkt_cnt + {15'd0, p_done && bus.ov_pkt_cnt != 16'hFFFF};
      bus.ov_discard_cnt <= bus.ov_discard_cnt + {15'd0, disc_inc && bus.ov_discard_cnt != 16'hFFFF};
    end
  end
endmodule

// File: tb/tb_pkt_buffer_write.sv
// tb_pkt_buffer_write: directed and random stimulus against a packet-level reference model
module tb_pkt_buffer_write;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;
  pkt_buffer_write_if bif();
  pkt_buffer_write dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bif.slave));
  int checks = 0, errors = 0;
  int n_we = 0, n_done = 0;
  bit chk_en = 1'b0;
  logic [8:0] q[$];
  int mode = 0, nl = 0;
  logic [8:0] cb = 9'd0;
  logic e_we = 1'b0, e_done = 1'b0, e_derr = 1'b0, e_pend = 1'b0, p_err = 1'b0;
  logic [15:0] e_addr = 16'd0, e_pc = 16'd0, e_dc = 16'd0;
  logic [133:0] e_data = 134'd0;
  logic [8:0] e_dbid = 9'd0, p_bid = 9'd0;
  logic [7:0] e_dlen = 8'd0, p_len = 8'd0;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void finish_pkt(input bit term_err);
    e_pend = 1'b1;
    p_bid = cb;
`ifdef PKT_BUFFER_WRITE_OVERLEN_CHECK_EN
    p_len = nl >= 128 ? 8'd128 : 8'(nl);
    p_err = term_err || nl > 128;
`else
    p_len = (nl % 128 == 0) ? 8'd128 : 8'(nl % 128);
    p_err = term_err;
`endif
  endfunction

  function automatic void write_line();
`ifdef PKT_BUFFER_WRITE_OVERLEN_CHECK_EN
    if (nl < 128) begin
      e_we = 1'b1;
      e_addr = {cb, 7'(nl % 128)};
      e_data = bif.iv_pkt;
    end
`else
    e_we = 1'b1;
    e_addr = {cb, 7'(nl % 128)};
    e_data = bif.iv_pkt;
`endif
    nl++;
  endfunction

  task automatic model_step();
    logic head, tail, used;
    if (i_rst) begin
      q.delete();
      mode = 0;
      e_we = 1'b0;
      e_done = 1'b0;
      e_pend = 1'b0;
      e_pc = 16'd0;
      e_dc = 16'd0;
      return;
    end
    e_done = e_pend;
    e_dbid = p_bid;
    e_dlen = p_len;
    e_derr = p_err;
    if (e_pend && e_pc != 16'hFFFF) e_pc++;
    e_pend = 1'b0;
    e_we = 1'b0;
    used = 1'b0;
    head = bif.i_pkt_wr && bif.iv_pkt[133:132] == 2'b01;
    tail = bif.i_pkt_wr && bif.iv_pkt[133:132] == 2'b10;
    if (head) begin
      if (mode == 1) finish_pkt(1'b1);
      if (mode == 2 && e_dc != 16'hFFFF) e_dc++;
      if (q.size() > 0) begin
        cb = q.pop_front();
        mode = 1;
      end else if (bif.i_pkt_bufid_wr) begin
        cb = bif.iv_pkt_bufid;
        used = 1'b1;
        mode = 1;
      end else mode = 2;
      if (mode == 1) begin
        nl = 0;
        write_line();
      end
    end else if (bif.i_pkt_wr && mode == 1) begin
      write_line();
      if (tail) begin
        finish_pkt(1'b0);
        mode = 0;
      end
    end else if (tail && mode == 2) begin
      if (e_dc != 16'hFFFF) e_dc++;
      mode = 0;
    end
    if (bif.i_pkt_bufid_wr && !used && q.size() < 2) q.push_back(bif.iv_pkt_bufid);
  endtask

  always @(negedge i_clk) if (chk_en) begin
    chk("ready", bif.o_bufid_ready, q.size() < 2);
    chk("state", bif.pkt_buffer_write_state, mode);
    chk("wr_en", bif.o_pkt_wr_en, e_we);
    if (e_we) begin
      chk("waddr", bif.ov_pkt_waddr, e_addr);
      chk("wdata", bif.ov_pkt_wdata, e_data);
    end
    chk("done", bif.o_pkt_done, e_done);
    if (e_done) begin
      chk("done_bufid", bif.ov_done_bufid, e_dbid);
      chk("done_len", bif.ov_done_len, e_dlen);
      chk("done_err", bif.o_done_err, e_derr);
    end
    chk("pkt_cnt", bif.ov_pkt_cnt, e_pc);
    chk("discard_cnt", bif.ov_discard_cnt, e_dc);
    if (bif.o_pkt_wr_en) n_we++;
    if (bif.o_pkt_done) n_done++;
  end

  task automatic cyc();
    @(posedge i_clk);
    model_step();
    #1;
    bif.i_pkt_wr = 1'b0;
    bif.i_pkt_bufid_wr = 1'b0;
  endtask

  task automatic set_bid(input logic [8:0] b);
    bif.i_pkt_bufid_wr = 1'b1;
    bif.iv_pkt_bufid = b;
  endtask

  task automatic set_line(input logic [1:0] t);
    bif.i_pkt_wr = 1'b1;
    bif.iv_pkt = {t, 4'h0, $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    int w0, d0, hp, tp;
    bif.i_pkt_bufid_wr = 1'b0;
    bif.iv_pkt_bufid = 9'd0;
    bif.i_pkt_wr = 1'b0;
    bif.iv_pkt = 134'd0;
    chk_en = 1'b1;
    cyc();
    cyc();
    chk("rst_ready", bif.o_bufid_ready, 1'b1);
    chk("rst_state", bif.pkt_buffer_write_state, 2'd0);
    chk("rst_pkt_cnt", bif.ov_pkt_cnt, 16'd0);
    i_rst = 1'b0;
    // 4-line packet into bufid 0x05
    set_bid(9'h05); cyc();
    set_line(2'b01); cyc();
    chk("r24_addr0", bif.ov_pkt_waddr, 16'h0280);
    set_line(2'b11); cyc();
    set_line(2'b11); cyc();
    set_line(2'b10); cyc();
    chk("r24_addr3", bif.ov_pkt_waddr, 16'h0283);
    cyc();
    chk("r24_done", bif.o_pkt_done, 1'b1);
    chk("r24_bufid", bif.ov_done_bufid, 9'h05);
    chk("r24_len", bif.ov_done_len, 8'd4);
    chk("r24_err", bif.o_done_err, 1'b0);
    chk("r24_pkt_cnt", bif.ov_pkt_cnt, 16'd1);
    // bypass bufid on head with empty FIFO
    set_bid(9'h1A); set_line(2'b01); cyc();
    chk("r25_addr", bif.ov_pkt_waddr, 16'h0D00);
    set_line(2'b10); cyc();
    cyc();
    w0 = n_we;
    set_line(2'b01); cyc();
    chk("r26_state_disc", bif.pkt_buffer_write_state, 2'd2);
    set_line(2'b11); cyc();
    set_line(2'b10); cyc();
    chk("r26_state_idle", bif.pkt_buffer_write_state, 2'd0);
    chk("r26_discard_cnt", bif.ov_discard_cnt, 16'd1);
    cyc();
    chk("r26_no_writes", n_we, w0);
    // third bufid into a full FIFO is lost
    set_bid(9'h01); cyc();
    set_bid(9'h02); cyc();
    chk("r27_ready0", bif.o_bufid_ready, 1'b0);
    set_bid(9'h03); cyc();
    set_line(2'b01); cyc();
    chk("r27_addr1", bif.ov_pkt_waddr, 16'h0080);
    set_line(2'b10); cyc();
    set_line(2'b01); cyc();
    chk("r27_addr2", bif.ov_pkt_waddr, 16'h0100);
    set_line(2'b10); cyc();
    set_line(2'b01); cyc();
    chk("r27_lost", bif.pkt_buffer_write_state, 2'd2);
    set_line(2'b10); cyc();
    // simultaneous pop and push on a full FIFO
    set_bid(9'h07); cyc();
    set_bid(9'h08); cyc();
    set_bid(9'h09); set_line(2'b01); cyc();
    chk("r17_addr7", bif.ov_pkt_waddr, 16'h0380);
    set_line(2'b10); cyc();
    set_line(2'b01); cyc();
    chk("r17_addr8", bif.ov_pkt_waddr, 16'h0400);
    set_line(2'b10); cyc();
    set_line(2'b01); cyc();
    chk("r17_addr9", bif.ov_pkt_waddr, 16'h0480);
    set_line(2'b10); cyc();
    // head terminates an open packet
    set_bid(9'h10); cyc();
    set_bid(9'h11); cyc();
    set_line(2'b01); cyc();
    set_line(2'b11); cyc();
    set_line(2'b01); cyc();
    cyc();
    chk("r13_done", bif.o_pkt_done, 1'b1);
    chk("r13_bufid", bif.ov_done_bufid, 9'h10);
    chk("r13_len", bif.ov_done_len, 8'd2);
    chk("r13_err", bif.o_done_err, 1'b1);
    set_line(2'b10); cyc();
    cyc();
    chk("r13_next_len", bif.ov_done_len, 8'd2);
    chk("r13_next_err", bif.o_done_err, 1'b0);
    // 130-line packet
    set_bid(9'h44); cyc();
    w0 = n_we;
    set_line(2'b01); cyc();
    for (int i = 0; i < 128; i++) begin
      set_line(2'b11); cyc();
    end
    set_line(2'b10); cyc();
    cyc();
    chk("r28_done", bif.o_pkt_done, 1'b1);
`ifdef PKT_BUFFER_WRITE_OVERLEN_CHECK_EN
    chk("r28_len", bif.ov_done_len, 8'd128);
    chk("r28_err", bif.o_done_err, 1'b1);
    cyc();
    chk("r28_writes", n_we - w0, 128);
`else
    chk("r28_len", bif.ov_done_len, 8'd2);
    chk("r28_err", bif.o_done_err, 1'b0);
    cyc();
    chk("r28_writes", n_we - w0, 130);
`endif
    // reset mid-packet
    set_bid(9'h21); cyc();
    d0 = n_done;
    set_line(2'b01); cyc();
    set_line(2'b11); cyc();
    i_rst = 1'b1; cyc();
    i_rst = 1'b0;
    set_line(2'b11); cyc();
    set_line(2'b11); cyc();
    set_line(2'b10); cyc();
    cyc();
    cyc();
    chk("r29_no_done", n_done, d0);
    chk("r29_pkt_cnt", bif.ov_pkt_cnt, 16'd0);
    set_bid(9'h33); cyc();
    set_line(2'b01); cyc();
    set_line(2'b10); cyc();
    cyc();
    chk("r29_done", bif.o_pkt_done, 1'b1);
    chk("r29_bufid", bif.ov_done_bufid, 9'h33);
    chk("r29_len", bif.ov_done_len, 8'd2);
    // random traffic, alternating short and long packets
    for (int it = 0; it < 6000; it++) begin
      hp = ((it / 1500) % 2 == 1) ? 200 : 6;
      tp = ((it / 1500) % 2 == 1) ? 150 : 4;
      if ($urandom_range(3) == 0) set_bid(9'($urandom()));
      if ($urandom_range(2) != 0)
        set_line(($urandom_range(hp - 1) == 0) ? 2'b01 : ($urandom_range(tp - 1) == 0) ? 2'b10 : 2'b11);
      i_rst = ($urandom_range(799) == 0);
      cyc();
      i_rst = 1'b0;
    end
    cyc();
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_buffer_write.md
PKT_BUFFER_WRITE -- requirements
Module: pkt_buffer_write

Interface
REQ-001 SHALL have one clock and one reset: the clock is i_clk, and the reset is synchronous and active-high, named i_rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- i_clk  in  1  clock
- i_rst  in  1  sync active-high reset
- i_pkt_bufid_wr  in  1  bufid valid strobe
- iv_pkt_bufid  in  9  free buffer id
- o_bufid_ready  out  1  bufid FIFO not full
- i_pkt_wr  in  1  packet line valid
- iv_pkt  in  134  [133:132] 01 head, 11 body, 10 tail; [131:128] unused; [127:0] data
- o_pkt_wr_en  out  1  packet RAM write enable
- ov_pkt_waddr  out  16  {bufid[8:0], line[6:0]}
- ov_pkt_wdata  out  134  line written
- o_pkt_done  out  1  packet complete pulse
- ov_done_bufid  out  9  bufid of completed packet
- ov_done_len  out  8  lines written, 1..128
- o_done_err  out  1  completed packet truncated
- ov_pkt_cnt  out  16  packets stored
- ov_discard_cnt  out  16  packets discarded
- pkt_buffer_write_state  out  2  FSM state

Function
REQ-003 SHALL hold bufids in a 2-entry FIFO; o_bufid_ready=1 when occupancy<2.
REQ-004 A bufid write while the FIFO is full SHALL be dropped and SHALL NOT corrupt the stored entries.
REQ-005 FSM states SHALL be IDLE=0, WRITE=1, DISCARD=2.
REQ-006 In IDLE, a head line with the FIFO non-empty SHALL pop one bufid, write line 0, and go to WRITE.
REQ-007 In IDLE, a head line with the FIFO empty but i_pkt_bufid_wr high in the same cycle SHALL use iv_pkt_bufid directly (bypass) and SHALL NOT enqueue it.
REQ-008 In IDLE, a head line with no bufid available SHALL enter DISCARD; no RAM writes SHALL occur.
REQ-009 In IDLE, body or tail lines SHALL be ignored.
REQ-010 In WRITE, each valid line SHALL be written at the current line index, which then increments.
REQ-011 In WRITE, a tail line SHALL be written and the FSM SHALL return to IDLE.
REQ-012 In DISCARD, lines SHALL be dropped until a tail arrives, then the FSM SHALL go to IDLE and ov_discard_cnt SHALL increment.
REQ-013 A head line received in WRITE or DISCARD SHALL terminate the current packet as if a tail had arrived (done with o_done_err=1 in WRITE), then start the new packet per REQ-006..008.
REQ-014 Write latency SHALL be 1 cycle: the input line in cycle N produces o_pkt_wr_en/addr/data in cycle N+1.
REQ-015 o_pkt_done SHALL pulse for one cycle at N+2 after the tail input, together with bufid and len; ov_pkt_cnt SHALL increment in the same cycle.
REQ-016 Counters SHALL saturate at 0xFFFF.
REQ-017 A bufid pop and a push in the same cycle SHALL both succeed even when the FIFO is full.

Reset
REQ-018 On i_rst, the FSM SHALL go to IDLE and the FIFO SHALL be emptied.
REQ-019 On i_rst, all outputs SHALL be 0, except o_bufid_ready=1.
REQ-020 On i_rst, the counters SHALL clear.
REQ-021 Reset asserted mid-packet SHALL abort without a done pulse; the remaining lines of that packet after reset release SHALL be ignored until the next head.

Configuration
REQ-022 With PKT_BUFFER_WRITE_OVERLEN_CHECK_EN defined, lines beyond 128 SHALL NOT be written; the packet continues to its tail, then done with len=128 and o_done_err=1.
REQ-023 Without PKT_BUFFER_WRITE_OVERLEN_CHECK_EN, the line index SHALL wrap modulo 128, overwriting earlier lines; ov_done_len SHALL report (count mod 128, 0 reported as 128); o_done_err SHALL be set only per REQ-013.

Verification
REQ-024 Bufid 0x05 queued, then a 4-line packet (head, 2 body, tail) -> writes at addrs 0x0280..0x0283; done bufid=0x05, len=4, err=0; ov_pkt_cnt=1.
REQ-025 FIFO empty, head with i_pkt_bufid_wr=1 and bufid 0x1A in the same cycle -> line 0 written at 0x0D00; FIFO occupancy stays 0.
REQ-026 FIFO empty, a 3-line packet with no bufid -> no o_pkt_wr_en; ov_discard_cnt=1; FSM returns to IDLE after the tail.
REQ-027 Three bufid writes 0x01, 0x02, 0x03 with no packets -> o_bufid_ready=0 after the second; subsequent packets use 0x01, then 0x02; 0x03 is lost.
REQ-028 A 130-line packet with the macro defined -> 128 writes; done len=128, err=1. Without the macro -> 130 writes, lines 128-129 at line indices 0-1; len=2.
REQ-029 i_rst asserted after line 2 of a 5-line packet -> no done pulse; a following 2-line packet with a fresh bufid completes normally.
